// File: rtl/dc_arb_pkg.sv
// Shared definitions for the dcache port arbiter: grant state encoding and
// the width helper used to size the encoded read-grant id.
package dc_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10
  } arb_state_e;

  // Bits needed to encode n channels, never less than one.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/dc_arbiter_rr_pick.sv
// Combinational round-robin picker: selects the first eligible channel at or
// after rr_ptr, wrapping to the lowest eligible index below it.
module rr_pick
  import dc_arb_pkg::*;
#(
  parameter int NUM_RD = 2,
  parameter int ID_W   = clog2_min1(NUM_RD)
) (
  input  logic [NUM_RD-1:0] eligible,
  input  logic [ID_W-1:0]   rr_ptr,
  output logic [NUM_RD-1:0] pick_onehot,
  output logic [ID_W-1:0]   pick_id,
  output logic              pick_valid
);

  // First pass covers indices at/after the pointer; the second pass only
  // fires when none were found there, so it yields the wrapped winner.
  always_comb begin
    pick_onehot = '0;
    pick_id     = '0;
    pick_valid  = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (!pick_valid && eligible[i] && (int'(rr_ptr) <= i)) begin
        pick_valid     = 1'b1;
        pick_onehot[i] = 1'b1;
        pick_id        = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_RD; i++) begin
      if (!pick_valid && eligible[i]) begin
        pick_valid     = 1'b1;
        pick_onehot[i] = 1'b1;
        pick_id        = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/dc_arbiter_mp.sv
// dcache port arbiter: NUM_RD round-robin load-read channels plus one store
// write-FIFO drain channel with urgency and anti-starvation priority.
module dc_arbiter_mp
  import dc_arb_pkg::*;
#(
  parameter  int NUM_RD      = 2,
  parameter  int WAIT_W      = 3,
  parameter  int MAX_WR_WAIT = 4,
  localparam int ID_W        = clog2_min1(NUM_RD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_RD-1:0] rd_req,
  input  logic [NUM_RD-1:0] rd_conflict,
  input  logic              rd_done,
  input  logic              wr_fifo_empty,
  input  logic              wr_fifo_to_be_full,
  input  logic              wr_done,
  output logic              ren,
  output logic              wen,
  output logic [NUM_RD-1:0] rd_gnt,
  output logic [ID_W-1:0]   rd_gnt_id
);

  arb_state_e        state_q, state_n;
  logic [NUM_RD-1:0] gnt_q, gnt_n;
  logic [ID_W-1:0]   id_q, id_n;
  logic [ID_W-1:0]   ptr_q, ptr_n;
  logic [WAIT_W-1:0] starve_q, starve_n, starve_eff;

  logic [NUM_RD-1:0] eligible;
  logic [NUM_RD-1:0] pick_onehot;
  logic [ID_W-1:0]   pick_id;
  logic              pick_valid;
  logic [ID_W-1:0]   pick_ptr, ptr_after_owner;
  logic              owner_conflict, rd_finish, ptr_advance;
  logic              wr_urgent, wr_starved, arbitrate;

  assign eligible        = rd_req & ~rd_conflict;
  assign owner_conflict  = (state_q == ST_RD) && |(gnt_q & rd_conflict);
  assign rd_finish       = (state_q == ST_RD) && rd_done;
  assign ptr_advance     = rd_finish && !owner_conflict;
  assign ptr_after_owner = (id_q == ID_W'(NUM_RD - 1)) ? '0 : id_q + ID_W'(1);

  // A read finishing this cycle counts toward starvation immediately, so the
  // arbitration in its release cycle already sees the updated wait count.
  assign starve_eff = (rd_finish && (starve_q != '1)) ? starve_q + WAIT_W'(1) : starve_q;
  assign wr_urgent  = !wr_fifo_empty && wr_fifo_to_be_full;
  assign wr_starved = !wr_fifo_empty && (starve_eff >= WAIT_W'(MAX_WR_WAIT));
  assign pick_ptr   = ptr_advance ? ptr_after_owner : ptr_q;

  rr_pick #(
    .NUM_RD (NUM_RD),
    .ID_W   (ID_W)
  ) u_rr_pick (
    .eligible    (eligible),
    .rr_ptr      (pick_ptr),
    .pick_onehot (pick_onehot),
    .pick_id     (pick_id),
    .pick_valid  (pick_valid)
  );

  // Release and re-arbitration share one cycle so grants go back-to-back.
  always_comb begin
    state_n   = state_q;
    gnt_n     = gnt_q;
    id_n      = id_q;
    ptr_n     = pick_ptr;
    arbitrate = 1'b0;
    case (state_q)
      ST_IDLE: arbitrate = 1'b1;
      ST_RD:   arbitrate = owner_conflict || rd_done;
      ST_WR:   arbitrate = wr_done;
      default: arbitrate = 1'b1;
    endcase
    if (arbitrate) begin
      gnt_n = '0;
      id_n  = '0;
      if (wr_urgent || wr_starved) begin
        state_n = ST_WR;
      end else if (pick_valid) begin
        state_n = ST_RD;
        gnt_n   = pick_onehot;
        id_n    = pick_id;
      end else if (!wr_fifo_empty) begin
        state_n = ST_WR;
      end else begin
        state_n = ST_IDLE;
      end
    end
    if (wr_fifo_empty || (state_n == ST_WR)) begin
      starve_n = '0;
    end else begin
      starve_n = starve_eff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      id_q     <= '0;
      ptr_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_n;
      gnt_q    <= gnt_n;
      id_q     <= id_n;
      ptr_q    <= ptr_n;
      starve_q <= starve_n;
    end
  end

  // The state encoding is one-hot over RD/WR, so each grant is a register bit.
  assign ren       = state_q[0];
  assign wen       = state_q[1];
  assign rd_gnt    = gnt_q;
  assign rd_gnt_id = id_q;

endmodule

// File: tb/tb_dc_arbiter_mp.sv
// Directed self-checking bench for dc_arbiter_mp with NUM_RD=2, MAX_WR_WAIT=4.
module tb_dc_arbiter_mp;

  localparam int NUM_RD      = 2;
  localparam int WAIT_W      = 3;
  localparam int MAX_WR_WAIT = 4;

  logic              clk;
  logic              rst_n;
  logic [NUM_RD-1:0] rd_req;
  logic [NUM_RD-1:0] rd_conflict;
  logic              rd_done;
  logic              wr_fifo_empty;
  logic              wr_fifo_to_be_full;
  logic              wr_done;
  logic              ren;
  logic              wen;
  logic [NUM_RD-1:0] rd_gnt;
  logic [0:0]        rd_gnt_id;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  dc_arbiter_mp #(
    .NUM_RD      (NUM_RD),
    .WAIT_W      (WAIT_W),
    .MAX_WR_WAIT (MAX_WR_WAIT)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rd_req             (rd_req),
    .rd_conflict        (rd_conflict),
    .rd_done            (rd_done),
    .wr_fifo_empty      (wr_fifo_empty),
    .wr_fifo_to_be_full (wr_fifo_to_be_full),
    .wr_done            (wr_done),
    .ren                (ren),
    .wen                (wen),
    .rd_gnt             (rd_gnt),
    .rd_gnt_id          (rd_gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  task automatic apply_stimulus(input logic [1:0] req, input logic [1:0] conf,
                                input logic done, input logic empty,
                                input logic to_be_full, input logic wdone);
    rd_req             = req;
    rd_conflict        = conf;
    rd_done            = done;
    wr_fifo_empty      = empty;
    wr_fifo_to_be_full = to_be_full;
    wr_done            = wdone;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic e_ren, input logic e_wen,
                              input logic [1:0] e_gnt, input logic e_id);
    logic [4:0] obs;
    logic [4:0] exp;
    obs = {ren, wen, rd_gnt, rd_gnt_id};
    exp = {e_ren, e_wen, e_gnt, e_id};
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("[TB] FAIL %s: observed ren,wen,gnt,id=%b required %b", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset and idle
    rst_n = 1'b0;
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    #3;
    check_output("reset_async", 0, 0, 2'b00, 0);
    repeat (2) tick();
    check_output("reset_hold", 0, 0, 2'b00, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("idle_no_req", 0, 0, 2'b00, 0);
    end

    // Round-robin 0,1,0,1 back-to-back
    apply_stimulus(2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); check_output("rr_first_ch0", 1, 0, 2'b01, 0);
    apply_stimulus(2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); check_output("rr_ch1", 1, 0, 2'b10, 1);
    tick(); check_output("rr_ch0", 1, 0, 2'b01, 0);
    tick(); check_output("rr_ch1_again", 1, 0, 2'b10, 1);
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); check_output("req_drop_holds", 1, 0, 2'b10, 1);
    apply_stimulus(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); check_output("rd_release_idle", 0, 0, 2'b00, 0);
    apply_stimulus(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(); check_output("done_ignored_idle", 0, 0, 2'b00, 0);

    // Conflict drop; pointer must not move on a conflict release
    apply_stimulus(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); check_output("conf_grant_ch0", 1, 0, 2'b01, 0);
    apply_stimulus(2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); check_output("conf_drop_idle", 0, 0, 2'b00, 0);
    apply_stimulus(2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); check_output("conf_ptr_kept", 1, 0, 2'b01, 0);
    apply_stimulus(2'b11, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); check_output("conf_switch_ch1", 1, 0, 2'b10, 1);
    apply_stimulus(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); check_output("conf_end_idle", 0, 0, 2'b00, 0);

    // Starvation: four completed reads with FIFO non-empty force a write
    apply_stimulus(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); check_output("starve_rd1_ch0", 1, 0, 2'b01, 0);
    tick(); check_output("starve_rd2_ch1", 1, 0, 2'b10, 1);
    tick(); check_output("starve_rd3_ch0", 1, 0, 2'b01, 0);
    tick(); check_output("starve_rd4_ch1", 1, 0, 2'b10, 1);
    tick(); check_output("starve_force_wr", 0, 1, 2'b00, 0);
    tick(); check_output("wr_ignores_rd_done", 0, 1, 2'b00, 0);
    apply_stimulus(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); check_output("starve_cnt_cleared", 1, 0, 2'b01, 0);
    apply_stimulus(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); check_output("starve_end_idle", 0, 0, 2'b00, 0);

    // Urgency from IDLE, write held until wr_done
    apply_stimulus(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); check_output("urgent_wr", 0, 1, 2'b00, 0);
    apply_stimulus(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); check_output("urgent_hold", 0, 1, 2'b00, 0);
    apply_stimulus(2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); check_output("wr_hold_fifo_empty", 0, 1, 2'b00, 0);
    apply_stimulus(2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(); check_output("urgent_then_rd_ch1", 1, 0, 2'b10, 1);
    apply_stimulus(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); check_output("urgent_end_idle", 0, 0, 2'b00, 0);

    // Plain write, then wr_done coinciding with a new read request
    apply_stimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); check_output("plain_wr", 0, 1, 2'b00, 0);
    apply_stimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); check_output("simul_wr_done_rd", 1, 0, 2'b01, 0);

    // Asynchronous reset mid-read, then one-cycle grant latency after release
    apply_stimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check_output("reset_mid_rd", 0, 0, 2'b00, 0);
    #4;
    rst_n = 1'b1;
    apply_stimulus(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    check_output("post_reset_no_grant", 0, 0, 2'b00, 0);
    tick(); check_output("post_reset_grant", 1, 0, 2'b01, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dc_arbiter_mp.md
Name: dc_arbiter_mp

Overview:
- Next-generation dcache port arbiter.
- Arbitrates NUM_RD independent load-read channels and one store write-FIFO drain channel onto the single dcache port.
- Read channels are served round-robin. The write channel has urgency and anti-starvation priority.
- The grant is held until the owning transaction completes; a read grant is also dropped when its channel reports a conflict.
- Sits between the read-operand stage load ports, the store write FIFO and the dcache request interface.

Parameters:
- NUM_RD, 2: number of read requester channels (1..8).
- WAIT_W, 3: width of the write-starvation counter.
- MAX_WR_WAIT, 4: completed read grants allowed while the write FIFO is non-empty before a write is forced (must be less than 2^WAIT_W).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_req  in  NUM_RD  per-channel valid memory-read request.
- rd_conflict  in  NUM_RD  per-channel memory conflict; channel is ineligible and loses any held grant.
- rd_done  in  1  pulse: the currently granted read finished (read-operand load done).
- wr_fifo_empty  in  1  write FIFO has no entries.
- wr_fifo_to_be_full  in  1  write FIFO reaches full next cycle.
- wr_done  in  1  pulse: the current dcache write finished.
- ren  out  1  read grant active.
- wen  out  1  write grant active.
- rd_gnt  out  NUM_RD  one-hot owner of ren; zero when ren=0.
- rd_gnt_id  out  clog2(NUM_RD) (min 1)  encoded owner; 0 when ren=0.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; ren=0, wen=0, rd_gnt=0, rd_gnt_id=0; rr_ptr=0; starve_cnt=0.
- All outputs come from registers. A grant appears on the rising edge after the cycle in which arbitration selects it, so latency from request to grant is 1 cycle.
- ren and wen are never both 1.
- States and output encoding: IDLE (no grant), RD (ren=1), WR (wen=1).
- Arbitration runs each cycle in IDLE, and in the cycle a grant is released. Priority order, first match wins:
  1. !wr_fifo_empty & wr_fifo_to_be_full -> WR.
  2. !wr_fifo_empty & starve_cnt >= MAX_WR_WAIT -> WR.
  3. Any eligible channel (rd_req[i] & !rd_conflict[i]) -> RD. Owner is the first eligible channel at or after rr_ptr, wrapping modulo NUM_RD.
  4. !wr_fifo_empty -> WR.
  5. Otherwise -> IDLE.
- RD hold/release:
  - rd_done=1 -> release.
  - Owner's rd_conflict=1 -> release, regardless of rd_done.
  - Otherwise keep the same owner.
  - On release by rd_done, rr_ptr becomes (owner+1) mod NUM_RD. On release by conflict, rr_ptr is unchanged.
- WR hold/release: wr_done=1 -> release; otherwise hold. Urgency and starvation do not preempt an active read; they only act at the next arbitration.
- Back-to-back: on the release edge the arbitration result is loaded directly, so a new grant follows with no IDLE bubble.
  - Releasing RD via rd_done with the same channel still requesting lets that channel win again only if no other eligible channel precedes it in round-robin order.
- starve_cnt:
  - Cleared when wr_fifo_empty=1 or when WR is granted.
  - Otherwise incremented (saturating at 2^WAIT_W-1) on each rd_done while RD is held.
- rd_req for a channel dropping while it owns RD does not release the grant; only rd_done or conflict releases it.
- wr_fifo_empty rising during WR does not release the grant; only wr_done releases it.
- rd_done or wr_done arriving while the block is not in the matching state is ignored.
- Reset asserted mid-transaction drops the grant immediately and asynchronously. No grant is issued in the first cycle after reset release.

Decomposition:
- Shared package dc_arb_pkg: state encoding (IDLE=2'b00, RD=2'b01, WR=2'b10) and the clog2 function for rd_gnt_id width.
- One sub-module: rr_pick, a combinational round-robin picker. Inputs: eligible vector and rr_ptr. Outputs: one-hot, encoded id and any-valid flag.
- FSM, counter and grant registers stay in the top module and use the library dff cells with asynchronous reset.

Test Plan:
- Reset and idle: hold rst_n=0, then release with no requests -> ren=wen=0, rd_gnt=0 indefinitely. Assert rst_n=0 during RD -> ren drops in the same cycle.
- Round-robin: NUM_RD=2, both rd_req=1, rd_done pulsed each grant, wr_fifo_empty=1 -> grant ids 0,1,0,1 with no idle cycle between grants.
- Conflict drop: channel 1 granted, rd_conflict[1]=1 -> ren=0 or switch to channel 0 next edge; rr_ptr stays 1.
- Starvation: MAX_WR_WAIT=4, write FIFO non-empty, continuous reads -> exactly 4 read grants complete, then wen=1. starve_cnt=0 after WR is granted.
- Urgency: in IDLE with read requests pending and wr_fifo_to_be_full=1 -> wen=1 next edge, ren=0. Hold until wr_done, then the read is granted next edge.
- Simultaneous: wr_done=1 in the same cycle rd_req[0] rises, FIFO not empty or full, starve_cnt=0 -> next edge ren=1, rd_gnt=01, wen=0.
